// File: rtl/mul_operand_loader_if.sv
// Operand loader bus: serial framing inputs, operand handshake, status.
// master = the loader itself, slave = the environment around it.
interface mul_operand_loader_if;
  logic        frame_start;
  logic        ser_a;
  logic        ser_b;
  logic        clr_err;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        err_ovr;
  logic        err_par;

  modport master (
    input  frame_start, ser_a, ser_b, clr_err, op_ready,
    output op_a, op_b, op_valid, busy, frame_cnt, err_ovr, err_par
  );

  modport slave (
    output frame_start, ser_a, ser_b, clr_err, op_ready,
    input  op_a, op_b, op_valid, busy, frame_cnt, err_ovr, err_par
  );
endinterface

// File: rtl/mul_operand_loader.sv
// Serial operand front end: deserializes two MSB-first 16-bit streams framed
// by frame_start, commits both operands together and offers them over
// valid/ready. Optional macro PARITY_CHECK_EN adds a 17th even-parity bit per
// line; failing frames are dropped and flagged on err_par.
module mul_operand_loader (
  input  logic                      clk,
  input  logic                      rst_n,
  mul_operand_loader_if.master      bus
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

  state_t      r_state, w_state;
  logic [3:0]  r_bit_cnt, w_bit_cnt;
  logic [15:0] r_sr_a, w_sr_a, r_sr_b, w_sr_b;
  logic [15:0] r_op_a, w_op_a, r_op_b, w_op_b;
  logic [7:0]  r_frame_cnt, w_frame_cnt;
  logic        r_op_valid, r_busy;
  logic        r_err_ovr, w_err_ovr, w_set_ovr;
  logic [15:0] w_sh_a, w_sh_b;
  logic        w_busy_nxt;

  assign w_sh_a = {r_sr_a[14:0], bus.ser_a};
  assign w_sh_b = {r_sr_b[14:0], bus.ser_b};

`ifdef PARITY_CHECK_EN
  logic r_err_par, w_err_par, w_set_par;
  // Even parity over 16 data bits plus the parity bit on the line.
  logic w_par_ok;
  assign w_par_ok = ~(^{r_sr_a, bus.ser_a}) & ~(^{r_sr_b, bus.ser_b});
  assign w_busy_nxt = (w_state == SHIFT) || (w_state == PAR);
`else
  assign w_busy_nxt = (w_state == SHIFT);
`endif

  // Next-state and datapath decode; set beats clear on the sticky flags.
  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_sr_a      = r_sr_a;
    w_sr_b      = r_sr_b;
    w_op_a      = r_op_a;
    w_op_b      = r_op_b;
    w_frame_cnt = r_frame_cnt;
    w_set_ovr   = 1'b0;
`ifdef PARITY_CHECK_EN
    w_set_par   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_state   = SHIFT;
          w_bit_cnt = 4'd0;
        end
      end
      SHIFT: begin
        if (bus.frame_start) begin
          // restart: partial data is simply overwritten by the new frame
          w_bit_cnt = 4'd0;
        end else begin
          w_sr_a    = w_sh_a;
          w_sr_b    = w_sh_b;
          w_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) begin
`ifdef PARITY_CHECK_EN
            w_state = PAR;
`else
            w_op_a      = w_sh_a;
            w_op_b      = w_sh_b;
            w_frame_cnt = r_frame_cnt + 8'd1;
            w_state     = HOLD;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (bus.frame_start) begin
          w_state   = SHIFT;
          w_bit_cnt = 4'd0;
        end else if (w_par_ok) begin
          w_op_a      = r_sr_a;
          w_op_b      = r_sr_b;
          w_frame_cnt = r_frame_cnt + 8'd1;
          w_state     = HOLD;
        end else begin
          w_set_par = 1'b1;
          w_state   = IDLE;
        end
      end
`endif
      HOLD: begin
        if (bus.op_ready) begin
          if (bus.frame_start) begin
            w_state   = SHIFT;
            w_bit_cnt = 4'd0;
          end else begin
            w_state = IDLE;
          end
        end else if (bus.frame_start) begin
          w_set_ovr = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    w_err_ovr = w_set_ovr ? 1'b1 : (bus.clr_err ? 1'b0 : r_err_ovr);
`ifdef PARITY_CHECK_EN
    w_err_par = w_set_par ? 1'b1 : (bus.clr_err ? 1'b0 : r_err_par);
`endif
  end

  // State and output registers; op_valid/busy registered from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_sr_a      <= 16'd0;
      r_sr_b      <= 16'd0;
      r_op_a      <= 16'd0;
      r_op_b      <= 16'd0;
      r_frame_cnt <= 8'd0;
      r_op_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_sr_a      <= w_sr_a;
      r_sr_b      <= w_sr_b;
      r_op_a      <= w_op_a;
      r_op_b      <= w_op_b;
      r_frame_cnt <= w_frame_cnt;
      r_op_valid  <= (w_state == HOLD);
      r_busy      <= w_busy_nxt;
      r_err_ovr   <= w_err_ovr;
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky parity error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_par <= 1'b0;
    else        r_err_par <= w_err_par;
  end
  assign bus.err_par = r_err_par;
`else
  assign bus.err_par = 1'b0;
`endif

  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.op_valid  = r_op_valid;
  assign bus.busy      = r_busy;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_mul_operand_loader.sv
// Scoreboard bench for mul_operand_loader; honours PARITY_CHECK_EN.
module tb_mul_operand_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_operand_loader_if bus();

  mul_operand_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  c;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  m_cnt = 8'd0;
  logic [15:0] last_a = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Pops/compares on each handshake the upcoming edge will accept, then steps.
  task automatic cyc();
    exp_t e;
    if (rst_n && bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("stray_commit", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("op_a", 32'(bus.op_a), 32'(e.a));
        chk("op_b", 32'(bus.op_b), 32'(e.b));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(e.c));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    m_cnt  = m_cnt + 8'd1;
    e.a = a; e.b = b; e.c = m_cnt;
    sbq.push_back(e);
    last_a = a;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic pa, input logic pb, input logic good);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    for (int i = 15; i >= 1; i--) begin
      bus.ser_a = a[i];
      bus.ser_b = b[i];
      cyc();
    end
    bus.ser_a = a[0];
    bus.ser_b = b[0];
`ifdef PARITY_CHECK_EN
    cyc();
    bus.ser_a = pa;
    bus.ser_b = pb;
`else
    if (pa | pb) begin end
`endif
    chk("valid_pre", 32'(bus.op_valid), 32'd0);
    cyc();
    chk("valid_at_commit", 32'(bus.op_valid), 32'(good));
  endtask

  task automatic start_partial(input int n);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.ser_a = 1'($urandom_range(0, 1));
      bus.ser_b = 1'($urandom_range(0, 1));
      cyc();
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    bus.frame_start = 1'b0;
    bus.ser_a = 1'b0;
    bus.ser_b = 1'b0;
    bus.clr_err = 1'b0;
    bus.op_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_op_a", 32'(bus.op_a), 32'd0);
    chk("rst_op_b", 32'(bus.op_b), 32'd0);
    chk("rst_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_ovr", 32'(bus.err_ovr), 32'd0);
    chk("rst_par", 32'(bus.err_par), 32'd0);
    cyc();

    // basic load, one-cycle valid with ready high
    bus.op_ready = 1'b1;
    push(16'h1234, 16'h00FF);
    send_frame(16'h1234, 16'h00FF, ^16'h1234, ^16'h00FF, 1'b1);
    chk("busy_in_hold", 32'(bus.busy), 32'd0);
    cyc();
    chk("valid_drop", 32'(bus.op_valid), 32'd0);
    cyc();

    // back-pressure and overrun
    bus.op_ready = 1'b0;
    push(16'h0F0F, 16'h3C3C);
    send_frame(16'h0F0F, 16'h3C3C, ^16'h0F0F, ^16'h3C3C, 1'b1);
    cyc();
    chk("bp_valid", 32'(bus.op_valid), 32'd1);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    chk("ovr_valid", 32'(bus.op_valid), 32'd1);
    chk("ovr_op_a", 32'(bus.op_a), 32'h0F0F);
    chk("ovr_flag", 32'(bus.err_ovr), 32'd1);
    cyc();
    chk("ovr_not_busy", 32'(bus.busy), 32'd0);
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("ovr_clr", 32'(bus.err_ovr), 32'd0);
    chk("ovr_still_valid", 32'(bus.op_valid), 32'd1);

    // back-to-back: handshake and frame_start on the same cycle
    bus.op_ready = 1'b1;
    push(16'hFFFF, 16'h8001);
    send_frame(16'hFFFF, 16'h8001, ^16'hFFFF, ^16'h8001, 1'b1);
    chk("b2b_no_ovr", 32'(bus.err_ovr), 32'd0);

    // restart at bit 7, then a full frame; only one commit
    start_partial(7);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    push(16'hA5A5, 16'h5A5A);
    send_frame(16'hA5A5, 16'h5A5A, ^16'hA5A5, ^16'h5A5A, 1'b1);
    cyc();

`ifdef PARITY_CHECK_EN
    // wrong parity on A: dropped and flagged
    send_frame(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("par_err", 32'(bus.err_par), 32'd1);
    chk("par_op_a_kept", 32'(bus.op_a), 32'(last_a));
    chk("par_cnt_kept", 32'(bus.frame_cnt), 32'(m_cnt));
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("par_clr", 32'(bus.err_par), 32'd0);
    push(16'h0001, 16'h0000);
    send_frame(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("par_ok_flag", 32'(bus.err_par), 32'd0);
`else
    chk("par_tied", 32'(bus.err_par), 32'd0);
`endif

    // reset mid-frame at bit 10 discards everything
    start_partial(10);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    m_cnt = 8'd0;
    chk("mrst_valid", 32'(bus.op_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("mrst_op_a", 32'(bus.op_a), 32'd0);
    repeat (2) cyc();
    chk("mrst_no_commit", 32'(bus.op_valid), 32'd0);

    // 256 good frames: frame_cnt wraps to 0
    for (int k = 0; k < 256; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      push(ra, rb);
      send_frame(ra, rb, ^ra, ^rb, 1'b1);
    end
    chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
    cyc();
    cyc();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
